// File: rtl/sbox_col_scheduler_pkg.sv
// Shared types and helpers for the time-shared S-box column scheduler.
package sbox_col_scheduler_pkg;

  localparam int BYTE_W    = 8;
  localparam int COL_W     = 32;
  localparam int STATE_W   = 128;
  localparam int NCOL      = 4;
  localparam int NUM_LANES = COL_W / BYTE_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ST_PASS = 3'd1,
    S_ST_DONE = 3'd2,
    S_KW_PASS = 3'd3,
    S_KW_DONE = 3'd4
  } fsm_e;

  typedef enum logic {
    GRANT_ST = 1'b0,
    GRANT_KW = 1'b1
  } grant_e;

  // Column c of the state occupies bits [127-32c -: 32]; column 0 holds byte 0 at the MSB.
  function automatic logic [COL_W-1:0] get_col(input logic [STATE_W-1:0] s,
                                               input logic [1:0]         c);
    return s[STATE_W-1-COL_W*int'(c) -: COL_W];
  endfunction

  function automatic logic [STATE_W-1:0] put_col(input logic [STATE_W-1:0] s,
                                                 input logic [1:0]         c,
                                                 input logic [COL_W-1:0]   w);
    logic [STATE_W-1:0] r;
    r = s;
    r[STATE_W-1-COL_W*int'(c) -: COL_W] = w;
    return r;
  endfunction

endpackage

// File: rtl/sbox_col_scheduler_if.sv
// Request/result handshakes for the ST (round state) and KW (key word) requesters.
interface sbox_col_scheduler_if;
  import sbox_col_scheduler_pkg::*;

  logic               st_valid;
  logic               st_ready;
  logic [STATE_W-1:0] st_data;
  logic               st_out_valid;
  logic               st_out_ready;
  logic [STATE_W-1:0] st_out_data;

  logic               kw_valid;
  logic               kw_ready;
  logic [COL_W-1:0]   kw_data;
  logic               kw_out_valid;
  logic               kw_out_ready;
  logic [COL_W-1:0]   kw_out_data;

  modport master (
    output st_valid, st_data, st_out_ready, kw_valid, kw_data, kw_out_ready,
    input  st_ready, st_out_valid, st_out_data, kw_ready, kw_out_valid, kw_out_data
  );

  modport slave (
    input  st_valid, st_data, st_out_ready, kw_valid, kw_data, kw_out_ready,
    output st_ready, st_out_valid, st_out_data, kw_ready, kw_out_valid, kw_out_data
  );
endinterface

// File: rtl/sbox_col_scheduler_sbox_col.sv
// One 32-bit S-box column: four independent AES byte S-boxes, purely combinational.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] q
);
  // Forward AES S-box, row-major: entry 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign q = SBOX_TBL[a];
endmodule

module sbox_col
  import sbox_col_scheduler_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  output logic [COL_W-1:0] col_out
);
  logic [NUM_LANES-1:0][BYTE_W-1:0] lane_in;
  logic [NUM_LANES-1:0][BYTE_W-1:0] lane_out;

  assign lane_in = col_in;
  assign col_out = lane_out;

  sbox u_sbox [NUM_LANES-1:0] (
    .a (lane_in),
    .q (lane_out)
  );
endmodule

// File: rtl/sbox_col_scheduler.sv
// Arbitrates one S-box column between a 4-pass SubBytes (ST) and a 1-pass SubWord (KW).
module sbox_col_scheduler
  import sbox_col_scheduler_pkg::*;
#(
  parameter bit KEY_PRIORITY = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sbox_col_scheduler_if.slave  bus,
  output logic                 busy
);

  fsm_e               state, state_nxt;
  grant_e             last_grant;
  logic [1:0]         cnt;
  logic [STATE_W-1:0] buf128;
  logic [COL_W-1:0]   buf32;
  logic [COL_W-1:0]   sb_in, sb_out;
  logic               st_rdy, kw_rdy;

  // Grants only in IDLE; never both readies, and none while reset is asserted.
  always_comb begin
    st_rdy = 1'b0;
    kw_rdy = 1'b0;
    if (rst_n && state == S_IDLE) begin
      if (bus.st_valid && bus.kw_valid) begin
        if (KEY_PRIORITY || last_grant == GRANT_ST) kw_rdy = 1'b1;
        else                                        st_rdy = 1'b1;
      end else begin
        st_rdy = bus.st_valid;
        kw_rdy = bus.kw_valid;
      end
    end
  end

  // Next-state: ST walks columns 0..3, KW takes a single pass, DONE waits for consumption.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (st_rdy) state_nxt = S_ST_PASS;
                 else if (kw_rdy) state_nxt = S_KW_PASS;
      S_ST_PASS: if (cnt == 2'd3) state_nxt = S_ST_DONE;
      S_ST_DONE: if (bus.st_out_ready) state_nxt = S_IDLE;
      S_KW_PASS: state_nxt = S_KW_DONE;
      S_KW_DONE: if (bus.kw_out_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // The shared column sees the current ST column during ST passes, the key word otherwise.
  assign sb_in = (state == S_ST_PASS) ? get_col(buf128, cnt) : buf32;

  sbox_col u_sbox_col (
    .col_in  (sb_in),
    .col_out (sb_out)
  );

  // Capture requests, substitute in place, track last grant for fair arbitration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= 2'd0;
      last_grant <= GRANT_ST;
      buf128     <= '0;
      buf32      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (st_rdy) begin
            buf128     <= bus.st_data;
            cnt        <= 2'd0;
            last_grant <= GRANT_ST;
          end else if (kw_rdy) begin
            buf32      <= bus.kw_data;
            last_grant <= GRANT_KW;
          end
        end
        S_ST_PASS: begin
          buf128 <= put_col(buf128, cnt, sb_out);
          cnt    <= cnt + 2'd1;
        end
        S_KW_PASS: buf32 <= sb_out;
        default: ;
      endcase
    end
  end

  // Results are visible only in DONE; data reads zero otherwise.
  assign bus.st_ready     = st_rdy;
  assign bus.kw_ready     = kw_rdy;
  assign bus.st_out_valid = (state == S_ST_DONE);
  assign bus.kw_out_valid = (state == S_KW_DONE);
  assign bus.st_out_data  = (state == S_ST_DONE) ? buf128 : '0;
  assign bus.kw_out_data  = (state == S_KW_DONE) ? buf32  : '0;
  assign busy             = (state != S_IDLE);

endmodule
